// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word load-store sequencer; word-crossing
// accesses take two memory cycles or are flagged, depending on ALLOW_MISALIGN.
module load_store_unit #(
    parameter bit ALLOW_MISALIGN = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_bmask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;
    state_t      state, state_nxt;
    logic        we_q, err_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q, wdata_q, w0;
    logic        bad_f3, misaligned, illegal, acc, hi, split;
    logic [3:0]  smask;
    logic [7:0]  m8;
    logic [63:0] s64, win;
    logic [31:0] base, r, ext;

    always_comb begin
        bad_f3 = i_we ? (i_funct3[2] || i_funct3 == 3'b011)
                      : (i_funct3 == 3'b011 || i_funct3[2:1] == 2'b11);
        misaligned = (i_funct3[1:0] == 2'b01 && i_addr[0]) ||
                     (i_funct3[1:0] == 2'b10 && i_addr[1:0] != 2'b00);
        illegal = bad_f3 || (!ALLOW_MISALIGN && misaligned);
        smask = f3_q[1] ? 4'b1111 : f3_q[0] ? 4'b0011 : 4'b0001;
        m8 = {4'b0000, smask} << addr_q[1:0];
        s64 = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
        split = |m8[7:4];
        base = {addr_q[31:2], 2'b00};
        acc = state == ACC0 || state == ACC1;
        hi = state == ACC1;
        // load window built from the word arriving this cycle, so o_rdata is valid alongside o_done
        win = hi ? {i_mem_rdata, w0} : {32'b0, i_mem_rdata};
        r = win[{1'b0, addr_q[1:0], 3'b000} +: 32];
        ext = f3_q[1] ? r
            : f3_q[0] ? {{16{r[15] & ~f3_q[2]}}, r[15:0]}
                      : {{24{r[7] & ~f3_q[2]}}, r[7:0]};
        state_nxt = state == IDLE ? (i_req ? (illegal ? DONE : ACC0) : IDLE)
                  : state == ACC0 ? (split ? ACC1 : DONE)
                  : state == ACC1 ? DONE : IDLE;
        o_busy = state != IDLE;
        o_done = state == DONE;
        o_err = o_done && err_q;
        o_mem_addr = acc ? base + (hi ? 32'd4 : 32'd0) : 32'b0;
        o_mem_wdata = acc ? (hi ? s64[63:32] : s64[31:0]) : 32'b0;
        o_mem_bmask = acc ? (hi ? m8[7:4] : m8[3:0]) : 4'b0;
        o_mem_wren = acc && we_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            we_q <= 1'b0;
            err_q <= 1'b0;
            f3_q <= 3'b0;
            addr_q <= 32'b0;
            wdata_q <= 32'b0;
            w0 <= 32'b0;
            o_rdata <= 32'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && i_req) begin
                we_q <= i_we;
                f3_q <= i_funct3;
                addr_q <= i_addr;
                wdata_q <= i_wdata;
                err_q <= illegal;
                if (illegal && !i_we)
                    o_rdata <= 32'b0;
            end
            if (state == ACC0)
                w0 <= i_mem_rdata;
            if (acc && state_nxt == DONE && !we_q)
                o_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench; a byte-level memory model predicts writes,
// load results, latency and memory-cycle counts for both ALLOW_MISALIGN settings.
module tb_load_store_unit;
    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_req = 1'b0, i_we = 1'b0;
    logic [2:0]  i_funct3 = 3'b0;
    logic [31:0] i_addr = 32'b0, i_wdata = 32'b0, i_mem_rdata;
    logic        o_busy, o_done, o_err, o_mem_wren;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        d0_busy, d0_done, d0_err, d0_wren;
    logic [31:0] d0_rdata, d0_maddr, d0_mwdata;
    logic [3:0]  d0_bmask;

    logic [31:0] mem_lo [16];
    logic [31:0] mem_top;
    int n_tests = 0, n_fail = 0, cyc = 0, acc_cyc = 0, n_acc = 0;
    logic [31:0] last_rdata = 32'b0;

    typedef struct {logic [31:0] addr; logic [3:0] mask; logic [31:0] data;} wr_t;
    typedef struct {logic err; logic ld; logic [31:0] rdata; int lat; int acc;} done_t;
    typedef struct {logic err; logic ld; int lat;} d0_t;
    wr_t   exp_wr [$];
    done_t exp_done [$];
    d0_t   exp_d0 [$];

    load_store_unit #(.ALLOW_MISALIGN(1'b1)) u_dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .o_mem_bmask(o_mem_bmask), .o_mem_wren(o_mem_wren), .i_mem_rdata(i_mem_rdata)
    );

    load_store_unit #(.ALLOW_MISALIGN(1'b0)) u_dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we),
        .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
        .o_busy(d0_busy), .o_done(d0_done), .o_err(d0_err), .o_rdata(d0_rdata),
        .o_mem_addr(d0_maddr), .o_mem_wdata(d0_mwdata),
        .o_mem_bmask(d0_bmask), .o_mem_wren(d0_wren), .i_mem_rdata(32'h0)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    assign i_mem_rdata = (o_mem_addr == 32'hFFFFFFFC) ? mem_top :
                         (o_mem_addr[31:6] == 26'h0) ? mem_lo[o_mem_addr[5:2]] : 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        logic [31:0] w;
        w = (a[31:2] == 30'h3FFFFFFF) ? mem_top : (a[31:6] == 26'h0) ? mem_lo[a[5:2]] : 32'h0;
        return 8'(w >> {a[1:0], 3'b000});
    endfunction

    always @(negedge i_clk) begin
        wr_t w;
        done_t d;
        d0_t e;
        if (i_rst_n) begin
            if (o_mem_bmask != 4'b0) n_acc++;
            if (o_mem_wren) begin
                if (exp_wr.size() == 0) check("wr_unexp", 32'(o_mem_wren), 32'h0);
                else begin
                    w = exp_wr.pop_front();
                    check("wr_addr", o_mem_addr, w.addr);
                    check("wr_mask", 32'(o_mem_bmask), 32'(w.mask));
                    check("wr_data", o_mem_wdata, w.data);
                end
            end
            if (o_done) begin
                if (exp_done.size() == 0) check("done_unexp", 32'(o_done), 32'h0);
                else begin
                    d = exp_done.pop_front();
                    check("err", 32'(o_err), 32'(d.err));
                    check("latency", 32'(cyc - acc_cyc), 32'(d.lat));
                    check("mem_cycles", 32'(n_acc), 32'(d.acc));
                    check(d.ld ? "rdata" : "rdata_hold", o_rdata, d.rdata);
                end
                n_acc = 0;
            end
            if (d0_done) begin
                if (exp_d0.size() == 0) check("d0_done_unexp", 32'(d0_done), 32'h0);
                else begin
                    e = exp_d0.pop_front();
                    check("d0_err", 32'(d0_err), 32'(e.err));
                    check("d0_latency", 32'(cyc - acc_cyc), 32'(e.lat));
                    if (e.ld && e.err) check("d0_rdata", d0_rdata, 32'h0);
                end
            end
        end
    end

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int sz, off, k, t, accn;
        logic bad, mis, en;
        logic [7:0] b, m;
        logic [63:0] dd;
        logic [31:0] v, rd;
        @(negedge i_clk);
        t = 0;
        while (o_busy && t < 20) begin @(negedge i_clk); t++; end
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        bad = we ? (f3[2] || f3 == 3'd3) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        off = int'(a[1:0]);
        mis = (off % sz) != 0;
        m = 8'h0;
        dd = 64'h0;
        for (int j = 0; j < 8; j++) begin
            k = j - off;
            b = (k >= 0 && k < 4) ? 8'(wd >> (8 * k)) : 8'h0;
            en = k >= 0 && k < sz;
            m = m | (8'(en) << j);
            dd = dd | (64'(b) << (8 * j));
        end
        accn = (m[7:4] != 4'h0) ? 2 : 1;
        if (!bad && we) begin
            exp_wr.push_back('{{a[31:2], 2'b00}, m[3:0], dd[31:0]});
            if (accn == 2) exp_wr.push_back('{{a[31:2], 2'b00} + 32'd4, m[7:4], dd[63:32]});
        end
        v = 32'h0;
        for (int j = 0; j < sz; j++) v = v | (32'(get_byte(a + 32'(j))) << (8 * j));
        if (!f3[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        if (!we) last_rdata = bad ? 32'h0 : v;
        rd = last_rdata;
        exp_done.push_back('{bad, !we, rd, bad ? 1 : accn + 1, bad ? 0 : accn});
        exp_d0.push_back('{bad || mis, !we, (bad || mis) ? 1 : accn + 1});
        i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
        acc_cyc = cyc;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        t = 0;
        while ((exp_done.size() != 0 || exp_d0.size() != 0) && t < 20) begin @(negedge i_clk); t++; end
        check("timeout", 32'(exp_done.size() + exp_d0.size()), 32'h0);
        check("wr_missing", 32'(exp_wr.size()), 32'h0);
        exp_done.delete(); exp_d0.delete(); exp_wr.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(o_busy), 32'h0);
        check({tag, "_done"}, 32'(o_done), 32'h0);
        check({tag, "_err"}, 32'(o_err), 32'h0);
        check({tag, "_rdata"}, o_rdata, 32'h0);
        check({tag, "_maddr"}, o_mem_addr, 32'h0);
        check({tag, "_mwdata"}, o_mem_wdata, 32'h0);
        check({tag, "_bmask"}, 32'(o_mem_bmask), 32'h0);
        check({tag, "_wren"}, 32'(o_mem_wren), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_lo[i] = $urandom;
        mem_top = $urandom;
        repeat (3) @(posedge i_clk);
        #1 check_idle_outputs("reset");
        @(negedge i_clk) i_rst_n = 1'b1;

        mem_lo[4] = 32'h8899AABB; op(1'b0, 3'd2, 32'h10, 32'h0);
        mem_lo[4] = 32'h80FFFFFF; op(1'b0, 3'd0, 32'h13, 32'h0);
        op(1'b0, 3'd4, 32'h13, 32'h0);
        mem_lo[5] = 32'h0000A5C3; op(1'b0, 3'd1, 32'h13, 32'h0);
        op(1'b0, 3'd5, 32'h13, 32'h0);
        op(1'b1, 3'd1, 32'h21, 32'h1234ABCD);
        op(1'b1, 3'd2, 32'h23, 32'hDEADBEEF);
        op(1'b1, 3'd0, 32'h2E, 32'h000000A5);
        mem_top = 32'h33445566; mem_lo[0] = 32'h00002211;
        op(1'b0, 3'd2, 32'hFFFFFFFE, 32'h0);
        op(1'b0, 3'd3, 32'h10, 32'h0);
        op(1'b1, 3'd4, 32'h10, 32'h55AA55AA);
        op(1'b1, 3'd3, 32'h10, 32'h55AA55AA);
        op(1'b0, 3'd7, 32'h14, 32'h0);
        op(1'b0, 3'd2, 32'h02, 32'h0);
        op(1'b0, 3'd5, 32'h21, 32'h0);

        // reset while the first half of a split store is on the bus
        @(negedge i_clk);
        i_req = 1'b1; i_we = 1'b1; i_funct3 = 3'd2; i_addr = 32'h23; i_wdata = 32'hDEADBEEF;
        @(posedge i_clk);
        #1 i_req = 1'b0;
        check("acc0_wren", 32'(o_mem_wren), 32'h1);
        check("acc0_addr", o_mem_addr, 32'h20);
        #1 i_rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        repeat (2) @(posedge i_clk);
        @(negedge i_clk) i_rst_n = 1'b1;
        last_rdata = 32'h0; n_acc = 0;
        repeat (6) @(negedge i_clk);
        check("abort_idle", 32'(o_busy), 32'h0);

        op(1'b0, 3'd2, 32'h10, 32'h0);
        for (int i = 0; i < 30; i++)
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 32'($urandom_range(0, 59)), $urandom);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: ALLOW_MISALIGN, 1, 1 = split word-crossing accesses into two memory cycles; 0 = flag any misaligned access as an error.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  access request; sampled only in IDLE.
REQ-005 i_we  input  1  1 = store, 0 = load.
REQ-006 i_funct3  input  3  RV32I width code: 000 B, 001 H, 010 W; loads also allow 100 BU and 101 HU.
REQ-007 i_addr  input  32  byte address.
REQ-008 i_wdata  input  32  store data, right-aligned.
REQ-009 o_busy  output  1  high in any state other than IDLE.
REQ-010 o_done  output  1  one-cycle completion pulse.
REQ-011 o_err  output  1  qualified by o_done: illegal funct3, or misaligned access when ALLOW_MISALIGN=0.
REQ-012 o_rdata  output  32  extended load result, registered.
REQ-013 o_mem_addr / o_mem_wdata  output  32 / 32  word-aligned address and lane-positioned write data to the memory.
REQ-014 o_mem_bmask  output  4  byte-lane enables; o_mem_wren  output  1  write enable.
REQ-015 i_mem_rdata  input  32  memory read data, combinationally valid in the same cycle as o_mem_addr.

Function
REQ-016 FSM states: IDLE, ACC0, ACC1, DONE.
REQ-017 IDLE with i_req=1 shall register i_we, i_funct3, i_addr and i_wdata, then go to ACC0. If the request is illegal, it shall go to DONE with o_err=1 instead.
REQ-018 In IDLE, i_req=0 shall hold the FSM in IDLE. In every other state, i_req shall be ignored.
REQ-019 Let off = addr[1:0] and size = 1, 2 or 4. The access is split when off + size > 4.
REQ-020 ACC0 shall drive o_mem_addr = {addr[31:2], 2'b00}.
REQ-021 ACC1 shall drive o_mem_addr = {addr[31:2], 2'b00} + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-022 Store lane data: S64 = {32'b0, wdata} << (8*off). ACC0 shall drive S64[31:0]; ACC1 shall drive S64[63:32].
REQ-023 Store mask: M8 = (size mask 0001, 0011 or 1111) << off. ACC0 shall drive M8[3:0]; ACC1 shall drive M8[7:4].
REQ-024 o_mem_wren shall be 1 in ACC0/ACC1 for stores and 0 for loads.
REQ-025 For loads, o_mem_bmask shall still present M8 but has no write effect.
REQ-026 Loads: ACC0 shall capture i_mem_rdata into W0, and ACC1 into W1 (W1 = 0 if not split).
REQ-027 Load result: R = ({W1, W0} >> (8*off))[31:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU) from size. LW shall pass R through.
REQ-028 ACC0 shall go to ACC1 if split, otherwise to DONE. ACC1 shall always go to DONE. DONE shall always go to IDLE.
REQ-029 DONE: o_done = 1 for exactly one cycle.
REQ-029a DONE with a load: o_rdata shall be updated to R, or to 0 on error.
REQ-029b DONE with a store: o_rdata shall be unchanged.
REQ-030 Latency from the accepting edge to o_done high: 2 cycles non-split, 3 cycles split, 1 cycle error.
REQ-031 Outside ACC0/ACC1: o_mem_wren = 0, o_mem_bmask = 0, o_mem_addr = 0, o_mem_wdata = 0.
REQ-032 Illegal requests: stores with funct3[2]=1 or funct3=011; loads with funct3 in {011, 110, 111}.
REQ-033 An illegal request shall perform no memory cycle, including no wren.
REQ-034 A new request may be accepted in the cycle after DONE, i.e. back-to-back through IDLE.

Reset
REQ-035 i_rst_n low shall asynchronously force state to IDLE and clear all outputs and internal registers to 0.
REQ-036 Reset asserted mid-operation shall abort the access: no further memory write, and no o_done.
REQ-037 Operation shall resume on the first rising edge after i_rst_n deasserts.

Verification
REQ-038 LW 0x10, mem[0x10] = 0x8899AABB -> one ACC cycle with wren=0, o_done 2 cycles after accept, o_rdata = 0x8899AABB, o_err = 0.
REQ-039 mem[0x10] = 0x80FFFFFF; LB 0x13 -> o_rdata = 0xFFFFFF80; LBU 0x13 -> o_rdata = 0x00000080.
REQ-040 SH 0x21, wdata 0x1234ABCD -> single write: addr 0x20, bmask 0110, wdata 0x34ABCD00; o_done 2 cycles after accept.
REQ-041 SW 0x23, wdata 0xDEADBEEF, ALLOW_MISALIGN=1 -> two writes and o_done 3 cycles after accept:
  - first write: addr 0x20, bmask 1000, wdata 0xEF000000;
  - second write: addr 0x24, bmask 0111, wdata 0x00DEADBE.
REQ-042 LW 0xFFFFFFFE, mem[0xFFFFFFFC] = 0x33445566, mem[0x0] = 0x00002211 -> second address 0x00000000, o_rdata = 0x22113344.
REQ-043 Error and reset cases:
  - load funct3 = 011 -> no memory cycle, o_done and o_err 1 cycle after accept, o_rdata = 0.
  - ALLOW_MISALIGN=0 with LW 0x02 -> same error response.
  - reset in ACC0 of the split SW -> no second write, no o_done, all outputs 0.
